// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings and helpers.
package imm_ext_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_ZERO     = 3'd0,
    MODE_HIGH     = 3'd1,
    MODE_SIGN     = 3'd2,
    MODE_SIGN_SL2 = 3'd3,
    MODE_ZERO_SL2 = 3'd4
  } imm_mode_e;

  // Encodings above MODE_ZERO_SL2 are reserved and flagged as errors.
  function automatic logic mode_is_legal(logic [MODE_W-1:0] mode);
    return (mode <= MODE_ZERO_SL2);
  endfunction

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Request/result handshake bundle for imm_ext_pipe.
interface imm_ext_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_imm;
  logic [MODE_W-1:0] in_mode;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_value;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  // Producer of requests / consumer of results.
  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_value, out_tag, out_err
  );

  // The pipeline itself.
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_value, out_tag, out_err
  );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: zero/high/sign placement with optional shift by 2.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]   i_imm,
  input  logic [MODE_W-1:0] i_mode,
  output logic [OUT_W-1:0]  o_value,
  output logic              o_err
);

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_high;

  assign w_zext = {{(OUT_W-IN_W){1'b0}}, i_imm};
  assign w_sext = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
  assign w_high = {i_imm, {(OUT_W-IN_W){1'b0}}};

  // Select the extension by mode; reserved modes yield zero with the error flag.
  always_comb begin
    o_value = '0;
    o_err   = !mode_is_legal(i_mode);
    case (i_mode)
      MODE_ZERO:     o_value = w_zext;
      MODE_HIGH:     o_value = w_high;
      MODE_SIGN:     o_value = w_sext;
      MODE_SIGN_SL2: o_value = w_sext << 2;
      MODE_ZERO_SL2: o_value = w_zext << 2;
      default:       o_value = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage with a registered output and a one-entry skid buffer.
// in_ready is a register (skid empty), so upstream never sees out_ready combinationally.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_ext_pipe_if.slave bus
);

  // Room for the full immediate plus the two shifted-in zeros is required.
  if (OUT_W < IN_W + 2) begin : g_bad_width
    $fatal(1, "imm_ext_pipe: OUT_W must be at least IN_W+2");
  end

  logic [OUT_W-1:0] w_ext_value;
  logic             w_ext_err;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_imm   (bus.in_imm),
    .i_mode  (bus.in_mode),
    .o_value (w_ext_value),
    .o_err   (w_ext_err)
  );

  logic             r_out_valid, w_out_valid;
  logic [OUT_W-1:0] r_out_value, w_out_value;
  logic [TAG_W-1:0] r_out_tag,   w_out_tag;
  logic             r_out_err,   w_out_err;

  logic             r_skid_valid, w_skid_valid;
  logic [OUT_W-1:0] r_skid_value, w_skid_value;
  logic [TAG_W-1:0] r_skid_tag,   w_skid_tag;
  logic             r_skid_err,   w_skid_err;

  logic w_accept;
  logic w_drain;

  assign w_accept = bus.in_valid && !r_skid_valid;
  assign w_drain  = r_out_valid && bus.out_ready;

  // Next-state: refill the output register from skid first (FIFO order), else from input.
  always_comb begin
    w_out_valid  = r_out_valid;
    w_out_value  = r_out_value;
    w_out_tag    = r_out_tag;
    w_out_err    = r_out_err;
    w_skid_valid = r_skid_valid;
    w_skid_value = r_skid_value;
    w_skid_tag   = r_skid_tag;
    w_skid_err   = r_skid_err;
    if (flush) begin
      w_out_valid  = 1'b0;
      w_skid_valid = 1'b0;
    end else if (!r_out_valid || w_drain) begin
      if (r_skid_valid) begin
        // in_ready is low here, so no input can be accepted alongside this move.
        w_out_valid  = 1'b1;
        w_out_value  = r_skid_value;
        w_out_tag    = r_skid_tag;
        w_out_err    = r_skid_err;
        w_skid_valid = 1'b0;
      end else if (w_accept) begin
        w_out_valid = 1'b1;
        w_out_value = w_ext_value;
        w_out_tag   = bus.in_tag;
        w_out_err   = w_ext_err;
      end else begin
        w_out_valid = 1'b0;
      end
    end else if (w_accept) begin
      // Output stalled and full: park the new entry in the skid register.
      w_skid_valid = 1'b1;
      w_skid_value = w_ext_value;
      w_skid_tag   = bus.in_tag;
      w_skid_err   = w_ext_err;
    end
  end

  // State registers; reset clears payloads so outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_value  <= '0;
      r_out_tag    <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_value <= '0;
      r_skid_tag   <= '0;
      r_skid_err   <= 1'b0;
    end else begin
      r_out_valid  <= w_out_valid;
      r_out_value  <= w_out_value;
      r_out_tag    <= w_out_tag;
      r_out_err    <= w_out_err;
      r_skid_valid <= w_skid_valid;
      r_skid_value <= w_skid_value;
      r_skid_tag   <= w_skid_tag;
      r_skid_err   <= w_skid_err;
    end
  end

  assign bus.in_ready  = !r_skid_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.out_value = r_out_value;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe.
module tb_imm_ext_pipe;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned TAG_W = 5;

  logic clk;
  logic rst_n;
  logic flush;

  int n_checks;
  int n_fails;

  imm_ext_pipe_if #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .TAG_W (TAG_W)
  ) u_if ();

  imm_ext_pipe #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .TAG_W (TAG_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] mode, input logic [15:0] imm,
                       input logic [4:0] tag);
    u_if.in_valid = v;
    u_if.in_mode  = mode;
    u_if.in_imm   = imm;
    u_if.in_tag   = tag;
  endtask

  // Single request with out_ready high: result appears next cycle, then drains.
  task automatic send_one(input string name, input logic [2:0] mode, input logic [15:0] imm,
                          input logic [4:0] tag, input logic [31:0] exp_val,
                          input logic exp_err);
    u_if.out_ready = 1'b1;
    drive(1'b1, mode, imm, tag);
    step();
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    check_eq({name, "_valid"}, u_if.out_valid, 1);
    check_eq({name, "_value"}, u_if.out_value, exp_val);
    check_eq({name, "_tag"},   u_if.out_tag,   tag);
    check_eq({name, "_err"},   u_if.out_err,   exp_err);
    step();
    check_eq({name, "_drained"}, u_if.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b1;
    flush = 1'b0;
    u_if.out_ready = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_out_valid", u_if.out_valid, 0);
    check_eq("rst_in_ready",  u_if.in_ready,  1);
    check_eq("rst_out_value", u_if.out_value, 0);
    check_eq("rst_out_tag",   u_if.out_tag,   0);
    check_eq("rst_out_err",   u_if.out_err,   0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Extension modes, including reserved ones and the recovery after an error.
    send_one("sign_8000",  3'd2, 16'h8000, 5'd7,  32'hFFFF8000, 1'b0);
    send_one("high_1234",  3'd1, 16'h1234, 5'd1,  32'h12340000, 1'b0);
    send_one("ssl2_ffff",  3'd3, 16'hFFFF, 5'd2,  32'hFFFFFFFC, 1'b0);
    send_one("zsl2_ffff",  3'd4, 16'hFFFF, 5'd3,  32'h0003FFFC, 1'b0);
    send_one("zero_8001",  3'd0, 16'h8001, 5'd4,  32'h00008001, 1'b0);
    send_one("sign_7fff",  3'd2, 16'h7FFF, 5'd5,  32'h00007FFF, 1'b0);
    send_one("ssl2_4000",  3'd3, 16'h4000, 5'd6,  32'h00010000, 1'b0);
    send_one("ssl2_8000",  3'd3, 16'h8000, 5'd8,  32'hFFFE0000, 1'b0);
    send_one("ill6_00ff",  3'd6, 16'h00FF, 5'd9,  32'h00000000, 1'b1);
    send_one("after_ill",  3'd2, 16'h0001, 5'd10, 32'h00000001, 1'b0);
    send_one("ill5",       3'd5, 16'hFFFF, 5'd11, 32'h00000000, 1'b1);
    send_one("ill7",       3'd7, 16'h1234, 5'd12, 32'h00000000, 1'b1);

    // Back-to-back stream with out_ready high: one result per cycle, in order.
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd0, 16'(i + 1), 5'(i + 1));
      step();
      check_eq($sformatf("stream_tag%0d", i), u_if.out_tag, i + 1);
      check_eq($sformatf("stream_valid%0d", i), u_if.out_valid, 1);
      check_eq($sformatf("stream_rdy%0d", i), u_if.in_ready, 1);
    end
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    step();
    check_eq("stream_end", u_if.out_valid, 0);

    // Stall: tags 1,2 fill both entries, tag 3 is held off until room frees.
    u_if.out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h0011, 5'd1);
    step();
    check_eq("stall_t1_tag", u_if.out_tag, 1);
    check_eq("stall_t1_rdy", u_if.in_ready, 1);
    drive(1'b1, 3'd0, 16'h0012, 5'd2);
    step();
    check_eq("stall_t2_rdy", u_if.in_ready, 0);
    drive(1'b1, 3'd0, 16'h0013, 5'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq($sformatf("stall_hold_tag%0d", i), u_if.out_tag, 1);
      check_eq($sformatf("stall_hold_val%0d", i), u_if.out_value, 32'h11);
      check_eq($sformatf("stall_hold_rdy%0d", i), u_if.in_ready, 0);
    end
    u_if.out_ready = 1'b1;
    step();
    check_eq("stall_out2_tag", u_if.out_tag, 2);
    check_eq("stall_out2_val", u_if.out_value, 32'h12);
    check_eq("stall_out2_rdy", u_if.in_ready, 1);
    step();
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    check_eq("stall_out3_tag", u_if.out_tag, 3);
    check_eq("stall_out3_val", u_if.out_value, 32'h13);
    step();
    check_eq("stall_empty", u_if.out_valid, 0);

    // Flush with one entry held while a new request is offered (and accepted by ready).
    u_if.out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h0004, 5'd4);
    step();
    drive(1'b1, 3'd0, 16'h0005, 5'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    check_eq("flush1_valid", u_if.out_valid, 0);
    check_eq("flush1_rdy", u_if.in_ready, 1);
    u_if.out_ready = 1'b1;
    step();
    check_eq("flush1_after", u_if.out_valid, 0);

    // Flush with both entries full.
    u_if.out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h0014, 5'd20);
    step();
    drive(1'b1, 3'd0, 16'h0015, 5'd21);
    step();
    check_eq("flush2_full", u_if.in_ready, 0);
    drive(1'b1, 3'd0, 16'h0016, 5'd22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    check_eq("flush2_valid", u_if.out_valid, 0);
    check_eq("flush2_rdy", u_if.in_ready, 1);
    u_if.out_ready = 1'b1;
    step();
    check_eq("flush2_after", u_if.out_valid, 0);

    // Asynchronous reset mid-stall with both entries held.
    u_if.out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h0017, 5'd23);
    step();
    drive(1'b1, 3'd0, 16'h0018, 5'd24);
    step();
    drive(1'b0, 3'd0, 16'h0, 5'd0);
    check_eq("arst_pre_valid", u_if.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", u_if.out_valid, 0);
    check_eq("arst_rdy",   u_if.in_ready,  1);
    check_eq("arst_tag",   u_if.out_tag,   0);
    check_eq("arst_value", u_if.out_value, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_one("post_rst", 3'd0, 16'hABCD, 5'd13, 32'h0000ABCD, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
